// File: rtl/weight_fetch_server_pkg.sv
// Shared types and constants for the weight fetch path: operating modes and
// the per-mode beat totals used to fill the weight buffer.
package weight_fetch_server_pkg;

  typedef enum logic [1:0] {
    MODE1 = 2'd0,
    MODE2 = 2'd1,
    MODE3 = 2'd2,
    MODE4 = 2'd3
  } OP_MODE;

  localparam int BEAT_CNT_W = 7;

  localparam logic [BEAT_CNT_W-1:0] WB_BEATS_M12 = 7'd88;
  localparam logic [BEAT_CNT_W-1:0] WB_BEATS_M3  = 7'd19;
  localparam logic [BEAT_CNT_W-1:0] WB_BEATS_M4  = 7'd11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } wfs_state_e;

  function automatic logic [BEAT_CNT_W-1:0] mode_to_beats(input OP_MODE mode);
    case (mode)
      MODE1, MODE2: return WB_BEATS_M12;
      MODE3:        return WB_BEATS_M3;
      default:      return WB_BEATS_M4;
    endcase
  endfunction

endpackage

// File: rtl/weight_fetch_server_fifo.sv
// Two-entry beat FIFO that absorbs the SRAM read latency so the stream can
// stall on mem_req without dropping or repeating beats.
module weight_beat_fifo #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count,
  output logic              not_empty
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head      = mem[rd_ptr];
  assign not_empty = (count != 2'd0);

endmodule

// File: rtl/weight_fetch_server.sv
// Streams a mode-dependent number of 64-bit weight words from the weight SRAM
// to the weight buffer under a valid/mem_req handshake.
module weight_fetch_server
  import weight_fetch_server_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  OP_MODE            cur_mode,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mem_req,
  output logic              mem_data_valid,
  output logic [DATA_W-1:0] weight_data,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy,
  output logic              done
);

  wfs_state_e              state_q, state_d;
  logic [BEAT_CNT_W-1:0]   total_q;
  logic [BEAT_CNT_W-1:0]   issue_cnt;
  logic [BEAT_CNT_W-1:0]   acc_cnt;
  logic [ADDR_W-1:0]       base_q;
  logic                    vld_p1;
  logic                    done_q;

  logic                    launch;
  logic                    finish;
  logic                    ren;
  logic                    xfer;
  logic                    fifo_flush;
  logic [2:0]              credit;
  logic [DATA_W-1:0]       fifo_head;
  logic [1:0]              fifo_count;
  logic                    fifo_vld;

  assign xfer   = fifo_vld && mem_req;
  // Counting this cycle's pop lets a read issue into the slot being freed,
  // which keeps the stream at one beat per cycle with only two entries.
  assign credit = 3'(fifo_count) + 3'(vld_p1) - 3'(xfer);

  always_comb begin
    state_d    = state_q;
    launch     = 1'b0;
    finish     = 1'b0;
    ren        = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!abort && start && !done_q) begin
          launch  = 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (abort) begin
          fifo_flush = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          ren = (issue_cnt < total_q) && (credit < 3'd2);
          if (xfer && (acc_cnt == total_q - 7'd1)) begin
            finish     = 1'b1;
            fifo_flush = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      issue_cnt <= '0;
      acc_cnt   <= '0;
      vld_p1    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p1  <= ren;
      done_q  <= finish;
      if (launch) begin
        issue_cnt <= '0;
        acc_cnt   <= '0;
      end else begin
        if (ren) issue_cnt <= issue_cnt + 7'd1;
        if (xfer && state_q == ST_STREAM) acc_cnt <= acc_cnt + 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (launch) begin
      total_q <= mode_to_beats(cur_mode);
      base_q  <= base_addr;
    end
  end

  // Stage p1: SRAM word returns one cycle after the read and enters the FIFO.
  weight_beat_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fifo_flush),
    .push      (vld_p1),
    .din       (sram_rdata),
    .pop       (xfer),
    .head      (fifo_head),
    .count     (fifo_count),
    .not_empty (fifo_vld)
  );

  assign sram_ren       = ren;
  assign sram_addr      = (state_q == ST_STREAM) ? base_q + ADDR_W'(issue_cnt) : '0;
  assign mem_data_valid = fifo_vld;
  assign weight_data    = fifo_vld ? fifo_head : '0;
  assign busy           = (state_q == ST_STREAM);
  assign done           = done_q;

endmodule

// File: tb/tb_weight_fetch_server.sv
// Randomized bench for weight_fetch_server: an SRAM model returns address-tagged
// words and the delivered stream is compared with the expected word sequence.
module tb_weight_fetch_server;
  import weight_fetch_server_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  OP_MODE      cur_mode = MODE1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] base_addr = '0;
  logic        mem_req = 1'b0;
  logic        mem_data_valid;
  logic [63:0] weight_data;
  logic        sram_ren;
  logic [15:0] sram_addr;
  logic [63:0] sram_rdata;
  logic        busy;
  logic        done;

  logic [47:0] salt = 48'h0;
  int checks = 0;
  int errors = 0;

  logic [63:0] got_q[$];
  logic [15:0] addr_q[$];
  int ren_cnt, ren_stall, first_vld, first_xfer, last_xfer, done_cnt, done_k;
  int proto_err;
  logic busy_at_done, stall_vld;
  logic [63:0] stall_data;
  bit timeout;

  weight_fetch_server #(.ADDR_W(16), .DATA_W(64)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cur_mode       (cur_mode),
    .start          (start),
    .abort          (abort),
    .base_addr      (base_addr),
    .mem_req        (mem_req),
    .mem_data_valid (mem_data_valid),
    .weight_data    (weight_data),
    .sram_ren       (sram_ren),
    .sram_addr      (sram_addr),
    .sram_rdata     (sram_rdata),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // SRAM model: 1-cycle latency, garbage on cycles without a read.
  always @(posedge clk)
    sram_rdata <= sram_ren ? {salt, sram_addr} : {$urandom(), $urandom()};

  function automatic int beats_of(input OP_MODE m);
    if (m == MODE3) return 19;
    if (m == MODE4) return 11;
    return 88;
  endfunction

  // Reference: beat i carries the SRAM word at (base + i) mod 2^16.
  function automatic int first_bad_beat(input OP_MODE m, input logic [15:0] b);
    logic [15:0] a;
    for (int i = 0; i < beats_of(m); i++) begin
      a = b + 16'(i);
      if (i >= got_q.size()) return i;
      if (got_q[i] !== {salt, a}) return i;
    end
    if (got_q.size() != beats_of(m)) return beats_of(m);
    return -1;
  endfunction

  function automatic int first_bad_addr(input OP_MODE m, input logic [15:0] b);
    for (int i = 0; i < beats_of(m); i++) begin
      if (i >= addr_q.size()) return i;
      if (addr_q[i] !== b + 16'(i)) return i;
    end
    if (addr_q.size() != beats_of(m)) return beats_of(m);
    return -1;
  endfunction

  task automatic new_salt();
    salt = {16'($urandom()), $urandom()};
  endtask

  task automatic do_start(input OP_MODE m, input logic [15:0] b);
    cur_mode  = m;
    base_addr = b;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // pat 0: mem_req low for stall_n cycles then high; 1: toggle; 2: random.
  task automatic run_stream(input int pat, input int stall_n, input bit busy_start);
    logic prev_v, prev_x;
    logic [63:0] prev_d;
    got_q.delete(); addr_q.delete();
    ren_cnt = 0; ren_stall = -1; first_vld = -1; first_xfer = -1; last_xfer = -1;
    done_cnt = 0; done_k = -1; proto_err = 0; busy_at_done = 1'b1;
    stall_vld = 1'b0; stall_data = '0;
    prev_v = 1'b0; prev_x = 1'b0; prev_d = '0;
    for (int k = 0; k < 2000; k++) begin
      case (pat)
        0:       mem_req = (k >= stall_n);
        1:       mem_req = (k % 2 == 0);
        default: mem_req = ($urandom_range(0, 2) != 0);
      endcase
      start = busy_start && (k == 10);
      if (busy_start && k == 10) cur_mode = MODE1;
      #1;
      if (sram_ren === 1'b1) begin ren_cnt++; addr_q.push_back(sram_addr); end
      if (k == stall_n - 1) begin
        ren_stall = ren_cnt; stall_vld = mem_data_valid; stall_data = weight_data;
      end
      if (mem_data_valid === 1'b1 && first_vld < 0) first_vld = k;
      if (prev_v && !prev_x && (mem_data_valid !== 1'b1 || weight_data !== prev_d)) proto_err++;
      if (mem_data_valid !== 1'b1 && weight_data !== '0) proto_err++;
      if (done === 1'b1) begin done_cnt++; done_k = k; busy_at_done = busy; end
      prev_v = mem_data_valid; prev_d = weight_data;
      prev_x = mem_data_valid && mem_req;
      if (prev_x) begin
        got_q.push_back(weight_data);
        if (first_xfer < 0) first_xfer = k;
        last_xfer = k;
      end
      @(posedge clk); #1;
      if (done_cnt > 0 && k >= done_k + 3) break;
    end
    timeout = (done_cnt == 0);
    mem_req = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; cur_mode = MODE4; base_addr = 16'h1234; mem_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mem_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", mem_data_valid); end
    checks++; if (weight_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h want 0", weight_data); end
    checks++; if (sram_ren !== 1'b0) begin errors++; $display("FAIL reset_ren got %b want 0", sram_ren); end
    checks++; if (sram_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got %h want 0", sram_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    start = 1'b0; mem_req = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored busy got %b want 0", busy); end
  endtask

  task automatic test_mode4_stream();
    int bad;
    new_salt();
    do_start(MODE4, 16'h0100);
    run_stream(0, 0, 1'b0);
    checks++; if (timeout) begin errors++; $display("FAIL m4_timeout no done seen"); end
    bad = first_bad_beat(MODE4, 16'h0100);
    checks++; if (bad !== -1) begin errors++; $display("FAIL m4_beats first bad index %0d of %0d got", bad, got_q.size()); end
    checks++; if (first_vld !== 2) begin errors++; $display("FAIL m4_first_valid got cycle %0d want 2", first_vld); end
    checks++; if (last_xfer - first_xfer !== 10) begin errors++; $display("FAIL m4_throughput span got %0d want 10", last_xfer - first_xfer); end
    checks++; if (done_k !== last_xfer + 1) begin errors++; $display("FAIL m4_done_timing got %0d want %0d", done_k, last_xfer + 1); end
    checks++; if (ren_cnt !== 11) begin errors++; $display("FAIL m4_ren_cycles got %0d want 11", ren_cnt); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL m4_busy_at_done got %b want 0", busy_at_done); end
  endtask

  task automatic test_mode1_toggle();
    int bad;
    new_salt();
    do_start(MODE1, 16'h0000);
    run_stream(1, 0, 1'b0);
    checks++; if (timeout) begin errors++; $display("FAIL m1_timeout no done seen"); end
    bad = first_bad_beat(MODE1, 16'h0000);
    checks++; if (bad !== -1) begin errors++; $display("FAIL m1_beats first bad index %0d of %0d got", bad, got_q.size()); end
    checks++; if (proto_err !== 0) begin errors++; $display("FAIL m1_stability got %0d violations want 0", proto_err); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL m1_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_mode3_stall();
    int bad;
    logic [15:0] b;
    b = 16'($urandom());
    new_salt();
    do_start(MODE3, b);
    run_stream(0, 20, 1'b0);
    checks++; if (ren_stall !== 2) begin errors++; $display("FAIL m3_stall_reads got %0d want 2", ren_stall); end
    checks++; if (stall_vld !== 1'b1 || stall_data !== {salt, b}) begin
      errors++; $display("FAIL m3_stall_head got v=%b %h want v=1 %h", stall_vld, stall_data, {salt, b});
    end
    bad = first_bad_beat(MODE3, b);
    checks++; if (bad !== -1) begin errors++; $display("FAIL m3_beats first bad index %0d of %0d got", bad, got_q.size()); end
    checks++; if (proto_err !== 0) begin errors++; $display("FAIL m3_stability got %0d violations want 0", proto_err); end
  endtask

  task automatic test_abort();
    int n, dones, bad;
    n = 0; dones = 0;
    new_salt();
    do_start(MODE2, 16'($urandom()));
    mem_req = 1'b1;
    for (int k = 0; k < 100 && n < 5; k++) begin
      #1;
      if (mem_data_valid && mem_req) n++;
      @(posedge clk); #1;
    end
    checks++; if (n !== 5) begin errors++; $display("FAIL abort_pre_beats got %0d want 5", n); end
    mem_req = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (mem_data_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", mem_data_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    for (int k = 0; k < 4; k++) begin
      if (done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_done got %0d pulses want 0", dones); end
    new_salt();
    do_start(MODE4, 16'h0200);
    run_stream(0, 0, 1'b0);
    bad = first_bad_beat(MODE4, 16'h0200);
    checks++; if (bad !== -1) begin errors++; $display("FAIL abort_restart first bad index %0d of %0d got", bad, got_q.size()); end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    new_salt();
    do_start(MODE1, 16'h0040);
    mem_req = 1'b1;
    for (int k = 0; k < 200 && n < 40; k++) begin
      #1;
      if (mem_data_valid && mem_req) n++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0; start = 1'b1; cur_mode = MODE4;
    @(posedge clk); #1;
    checks++; if ({mem_data_valid, sram_ren, busy, done} !== 4'b0 || weight_data !== 64'h0 || sram_addr !== 16'h0) begin
      errors++; $display("FAIL midreset_outputs got v=%b ren=%b busy=%b done=%b data=%h addr=%h want all 0",
                         mem_data_valid, sram_ren, busy, done, weight_data, sram_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0; mem_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_start_ignored busy got %b want 0", busy); end
  endtask

  task automatic test_wrap_and_busy_start();
    int bad;
    new_salt();
    do_start(MODE4, 16'hFFFE);
    run_stream(0, 0, 1'b1);
    bad = first_bad_addr(MODE4, 16'hFFFE);
    checks++; if (bad !== -1) begin errors++; $display("FAIL wrap_addr first bad index %0d of %0d got", bad, addr_q.size()); end
    bad = first_bad_beat(MODE4, 16'hFFFE);
    checks++; if (bad !== -1) begin errors++; $display("FAIL wrap_beats first bad index %0d of %0d got", bad, got_q.size()); end
    checks++; if (ren_cnt !== 11) begin errors++; $display("FAIL busy_start_reads got %0d want 11", ren_cnt); end
  endtask

  task automatic test_random();
    OP_MODE m;
    logic [15:0] b;
    int bad;
    for (int it = 0; it < 4; it++) begin
      m = OP_MODE'($urandom_range(0, 3));
      b = 16'($urandom());
      new_salt();
      do_start(m, b);
      run_stream(2, 0, 1'b0);
      bad = first_bad_beat(m, b);
      checks++; if (bad !== -1) begin errors++; $display("FAIL rand_beats mode %0d base %h first bad %0d of %0d got", m, b, bad, got_q.size()); end
      checks++; if (done_cnt !== 1 || proto_err !== 0) begin
        errors++; $display("FAIL rand_proto done got %0d want 1, violations got %0d want 0", done_cnt, proto_err);
      end
      checks++; if (ren_cnt !== beats_of(m)) begin errors++; $display("FAIL rand_reads got %0d want %0d", ren_cnt, beats_of(m)); end
    end
  endtask

  initial begin
    test_reset();
    test_mode4_stream();
    test_mode1_toggle();
    test_mode3_stall();
    test_abort();
    test_reset_mid();
    test_wrap_and_busy_start();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
